// File: rtl/light_update_ctrl.sv
// rtl/light_update_ctrl.sv - ambient-light sample/map/PWM update scheduler
// Requests a sensor byte per tick, latches the mapped targets, slews duties on PWM wrap.
module light_update_ctrl #(
  parameter int SAMPLE_DIV = 1000000,
  parameter int TIMEOUT    = 4096,
  parameter int STEP       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       sample_req,
  input  logic       sample_ack,
  input  logic [7:0] sample_data,
  output logic [7:0] intensity,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  input  logic       pwm_wrap,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       timeout_err
);
  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [8:0] STEP9 = 9'(STEP);

  typedef enum logic [1:0] {IDLE, REQ, SETTLE, COMMIT} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic             tick_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [7:0]       tr_q, tg_q, tb_q;
  logic [7:0]       duty_r_q, duty_g_q, duty_b_q;
  logic [7:0]       intensity_q;
  logic             sample_req_q, busy_q, timeout_err_q;
  logic [7:0]       duty_r_d, duty_g_d, duty_b_d;
  logic             settled_d;

  // 9-bit compare so cur+STEP / tgt+STEP never wrap; no overshoot past tgt.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c, t;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c + STEP9)      return 8'(c + STEP9);
    else if (c > t + STEP9) return 8'(c - STEP9);
    else                    return tgt;
  endfunction

  always_comb begin
    duty_r_d  = slew(duty_r_q, tr_q);
    duty_g_d  = slew(duty_g_q, tg_q);
    duty_b_d  = slew(duty_b_q, tb_q);
    settled_d = (duty_r_d == tr_q) && (duty_g_d == tg_q) && (duty_b_d == tb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (!enable) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
      tick_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      to_cnt_q      <= '0;
      tr_q          <= '0;
      tg_q          <= '0;
      tb_q          <= '0;
      duty_r_q      <= '0;
      duty_g_q      <= '0;
      duty_b_q      <= '0;
      intensity_q   <= '0;
      sample_req_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick_q) begin
            state_q      <= REQ;
            sample_req_q <= 1'b1;
            busy_q       <= 1'b1;
            to_cnt_q     <= '0;
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the last allowed cycle still wins.
          if (sample_ack) begin
            intensity_q   <= sample_data;
            sample_req_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            state_q       <= SETTLE;
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            sample_req_q  <= 1'b0;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        SETTLE: begin
          tr_q    <= tgt_r;
          tg_q    <= tgt_g;
          tb_q    <= tgt_b;
          state_q <= COMMIT;
        end
        COMMIT: begin
          if (pwm_wrap) begin
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            if (settled_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_req  = sample_req_q;
  assign intensity   = intensity_q;
  assign duty_r      = duty_r_q;
  assign duty_g      = duty_g_q;
  assign duty_b      = duty_b_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/light_update_ctrl.md
Name: light_update_ctrl

Overview:
- Scheduler for the ambient-light datapath: sensor read, then colour mapping, then the three PWM channels.
- Periodically requests a sensor sample over a req/ack handshake and latches the result as the intensity presented to the colour mapper.
- Captures the mapped RGB targets and slews the three PWM duty values toward them, at most STEP per PWM period.
- Duty values change only on the PWM wrap pulse, so LED pulses are never glitched mid-period.

Parameters:
SAMPLE_DIV, 1000000, clocks between sample ticks (>=2)
TIMEOUT, 4096, max clocks sample_req is held without sample_ack (>=2)
STEP, 4, max duty change per channel per PWM period (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  permits new sample ticks
sample_req  out  1  sensor read request (level)
sample_ack  in  1  sensor data valid; single-cycle pulse
sample_data  in  8  sensor byte, valid with sample_ack
intensity  out  8  latched sample, drives colour mapper
tgt_r  in  8  mapped red target (combinational from intensity)
tgt_g  in  8  mapped green target
tgt_b  in  8  mapped blue target
pwm_wrap  in  1  one-cycle pulse at PWM counter wrap
duty_r  out  8  red pulse width to PWM
duty_g  out  8  green pulse width
duty_b  out  8  blue pulse width
busy  out  1  FSM not in IDLE
timeout_err  out  1  sticky: last request timed out

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n).
- Reset (async assert, sync release):
  - FSM = IDLE, timers = 0.
  - All outputs 0: sample_req, intensity, duty_*, busy, timeout_err.
  - rst_n low in any state aborts immediately; sample_req drops the same instant.
- Tick timer:
  - Counts 0..SAMPLE_DIV-1 while enable=1; tick is a one-cycle pulse at terminal count, then wraps to 0.
  - enable=0: timer held at 0, no ticks. An in-flight sequence still completes.
  - Tick outside IDLE: dropped; timer keeps running.
- FSM states:
  - IDLE: busy=0. Tick -> REQ, with sample_req=1 from the next cycle.
  - REQ: sample_req held high; timeout counter increments each cycle.
    - sample_ack=1: intensity <= sample_data, sample_req=0 next cycle, timeout_err cleared, -> SETTLE.
    - TIMEOUT cycles elapse with no ack: sample_req=0, timeout_err=1, intensity unchanged, -> IDLE.
    - sample_req is high exactly TIMEOUT cycles on timeout.
    - Ack on the final timeout cycle wins: accepted, no error.
  - SETTLE: one cycle for the mapper to settle on the new intensity. Latch tgt_* into internal target registers -> COMMIT. tgt_* are ignored in all other states.
  - COMMIT: per channel, compute next from current duty (cur) and target (tgt):
    - |tgt-cur| <= STEP: next = tgt.
    - Otherwise: next = cur+STEP if tgt>cur, cur-STEP if tgt<cur.
    - Unsigned 9-bit compare; no wrap, no overshoot.
    - On pwm_wrap=1: duty_* <= next, registered and visible the cycle after the wrap is sampled.
    - If all three next equal target: -> IDLE. Else stay in COMMIT; one step per wrap.
- pwm_wrap is consumed only while registered in COMMIT. A wrap coinciding with the SETTLE->COMMIT transition is ignored.
- Targets already equal to current duty: COMMIT still waits one pwm_wrap, writes the unchanged values, -> IDLE.
- sample_ack outside REQ: ignored.

Test Plan:
Bench parameters: SAMPLE_DIV=16, TIMEOUT=8, STEP=4.
1. Reset: assert rst_n low mid-COMMIT with duty_r=0x08 and sample_req high from a prior REQ -> all outputs 0 asynchronously; after release, first sample_req asserts 17 clocks later.
2. Upward ramp: enable=1, ack 2 cycles after req with sample_data=0x80, tgt=(0x0A,0x00,0x03) -> intensity=0x80; duty_r 0,4,8,0x0A and duty_b 0,3 on successive wraps; busy drops after the third wrap; duty_g stays 0.
3. Downward ramp: cur duty_r=0x0A, tgt_r=0x00 -> duty_r 0x06, 0x02, 0x00 on three wraps; no underflow.
4. Saturation: cur=0xFD, tgt=0xFF -> 0xFF in one wrap. cur=0x02, tgt=0x00 -> 0x00 in one wrap.
5. Timeout: sample_ack never asserted -> sample_req high exactly 8 cycles, timeout_err=1, intensity and duty_* unchanged; next request acked -> timeout_err=0.
6. Boundary: ack on 8th REQ cycle -> accepted, no error. Tick during COMMIT -> no extra request. enable=0 -> no sample_req for 100 cycles.
